// File: rtl/mem_write_sequencer.sv
// mem_write_sequencer: main data/instruction memory port of the multicycle core.
// - Reads: 1-cycle latency. The word, half and byte outputs come from the same
//   registered word.
// - Stores: word, half and byte. Sub-word stores use a read-modify-write on a
//   word-wide synchronous RAM.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   address[31:0]      byte address for reads and stores (little-endian)
//   write_mode[1:0]    00 none, 01 byte, 10 half, 11 word; held until done
//   write_byte/half_word/word  store data for the matching mode
//   word_output        registered word at address[ADDR_BITS+1:2]
//   half_word_output   half of that word selected by address[1] (1 = upper)
//   byte_output        byte of that word selected by address[1:0]
//   done               one-cycle pulse: store finished or rejected
//   error              last store request was rejected (misaligned/out of range)
module mem_write_sequencer #(
  parameter int  DEPTH_WORDS = 4096,
  localparam int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [1:0]  write_mode,
  input  logic [7:0]  write_byte,
  input  logic [15:0] write_half_word,
  input  logic [31:0] write_word,
  output logic [31:0] word_output,
  output logic [15:0] half_word_output,
  output logic [7:0]  byte_output,
  output logic        done,
  output logic        error
);

  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, HOLD} state_t;

  logic [31:0]          mem [DEPTH_WORDS];
  state_t               state;
  logic [ADDR_BITS-1:0] cap_idx;
  logic [1:0]           cap_lane;
  logic [1:0]           cap_mode;
  logic [31:0]          cap_data;
  logic [31:0]          old_word;
  logic [31:0]          merged;
  logic [31:0]          rd_word;
  logic [1:0]           rd_lane;
  logic                 in_range;
  logic                 reject;

  assign in_range = ({1'b0, address} < BYTE_LIMIT);

  // Misaligned half/word stores and any out-of-range store never touch the RAM.
  always_comb begin
    reject = !in_range;
    if (write_mode == 2'b10 && address[0])         reject = 1'b1;
    if (write_mode == 2'b11 && address[1:0] != '0) reject = 1'b1;
  end

  // Read path.
  // - Old data on read-during-write falls out of the nonblocking RAM update.
  // - An out-of-range read loads zero, so every lane select yields zero too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_word <= '0;
      rd_lane <= '0;
    end else begin
      rd_word <= in_range ? mem[address[ADDR_BITS+1:2]] : '0;
      rd_lane <= address[1:0];
    end
  end

  assign word_output      = rd_word;
  assign half_word_output = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign byte_output      = rd_word[{rd_lane, 3'b000} +: 8];

  // Merge captured store data into the old word.
  // - Word stores bypass old_word entirely.
  always_comb begin
    merged = old_word;
    case (cap_mode)
      2'b01:   merged[{cap_lane, 3'b000} +: 8]        = cap_data[7:0];
      2'b10:   merged[{cap_lane[1], 4'b0000} +: 16]   = cap_data[15:0];
      default: merged = cap_data;
    endcase
  end

  // Single-edge commit.
  // - Reset forces state to IDLE asynchronously, so a pending store is dropped
  //   before its WRITE edge.
  always_ff @(posedge clk) begin
    if (state == WRITE) mem[cap_idx] <= merged;
  end

  // Control FSM.
  // - done is registered and raised on the edge that enters DONE, so it is high
  //   for exactly the DONE cycle.
  // - HOLD waits for write_mode to drop, so a held request is not re-executed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      error    <= 1'b0;
      cap_idx  <= '0;
      cap_lane <= '0;
      cap_mode <= '0;
      cap_data <= '0;
      old_word <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (write_mode != 2'b00) begin
          cap_idx  <= address[ADDR_BITS+1:2];
          cap_lane <= address[1:0];
          cap_mode <= write_mode;
          case (write_mode)
            2'b01:   cap_data <= {24'h0, write_byte};
            2'b10:   cap_data <= {16'h0, write_half_word};
            default: cap_data <= write_word;
          endcase
          if (reject) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            error <= 1'b0;
            state <= (write_mode == 2'b11) ? WRITE : READ;
          end
        end
        READ: begin
          old_word <= mem[cap_idx];
          state    <= WRITE;
        end
        WRITE: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: state <= HOLD;
        HOLD: if (write_mode == 2'b00) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_sequencer.sv
module tb_mem_write_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [1:0]  write_mode = '0;
  logic [7:0]  write_byte = '0;
  logic [15:0] write_half_word = '0;
  logic [31:0] write_word = '0;
  logic [31:0] word_output;
  logic [15:0] half_word_output;
  logic [7:0]  byte_output;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  mem_write_sequencer #(.DEPTH_WORDS(4096)) dut (
    .clk(clk), .rst(rst), .address(address), .write_mode(write_mode),
    .write_byte(write_byte), .write_half_word(write_half_word),
    .write_word(write_word), .word_output(word_output),
    .half_word_output(half_word_output), .byte_output(byte_output),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one store.
  // - After capture, the address moves to late_addr and the data is inverted.
  // - Checks: latency in edges (sample edge counts as 1), error, a single done
  //   pulse while the mode is held, then the mode drops for one cycle.
  task automatic store(input string tag, input logic [31:0] addr, input logic [1:0] mode,
                       input logic [31:0] data, input logic [31:0] late_addr,
                       input int exp_lat, input logic exp_err);
    int cnt;
    address         = addr;
    write_mode      = mode;
    write_byte      = data[7:0];
    write_half_word = data[15:0];
    write_word      = data;
    tick();
    address         = late_addr;
    write_byte      = ~data[7:0];
    write_half_word = ~data[15:0];
    write_word      = ~data;
    cnt = 1;
    while (!done && cnt < 8) begin
      tick();
      cnt++;
    end
    chk({tag, ".latency"}, 32'(cnt), 32'(exp_lat));
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".error"}, 32'(error), 32'(exp_err));
    tick();
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    tick();
    chk({tag, ".no_redo"}, 32'(done), 32'd0);
    write_mode = 2'b00;
    tick();
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] ew,
                    input logic [15:0] eh, input logic [7:0] eb);
    address = addr;
    tick();
    chk({tag, ".word"}, word_output, ew);
    chk({tag, ".half"}, 32'(half_word_output), 32'(eh));
    chk({tag, ".byte"}, 32'(byte_output), 32'(eb));
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    chk("rst.word", word_output, 32'd0);
    rst = 1'b0;
    tick();

    // Word store; a held mode must not cause a second done.
    store("w10", 32'h10, 2'b11, 32'hDEADBEEF, 32'h10, 2, 1'b0);
    rd("rd10", 32'h10, 32'hDEADBEEF, 16'hBEEF, 8'hEF);
    rd("rd12", 32'h12, 32'hDEADBEEF, 16'hDEAD, 8'hAD);
    rd("rd11", 32'h11, 32'hDEADBEEF, 16'hBEEF, 8'hBE);

    // Read-modify-write of byte and half.
    store("w20", 32'h20, 2'b11, 32'h11223344, 32'h20, 2, 1'b0);
    store("b22", 32'h22, 2'b01, 32'h000000AA, 32'h22, 3, 1'b0);
    rd("rd20a", 32'h20, 32'h11AA3344, 16'h3344, 8'h44);
    store("h20", 32'h20, 2'b10, 32'h00005566, 32'h20, 3, 1'b0);
    rd("rd20b", 32'h20, 32'h11AA5566, 16'h5566, 8'h66);

    // Misaligned stores are rejected and leave memory unchanged.
    store("h21", 32'h21, 2'b10, 32'h0000FFFF, 32'h21, 1, 1'b1);
    store("w22", 32'h22, 2'b11, 32'hFFFFFFFF, 32'h22, 1, 1'b1);
    chk("err.persist", 32'(error), 32'd1);
    rd("rd20c", 32'h20, 32'h11AA5566, 16'h5566, 8'h66);
    store("w24", 32'h24, 2'b11, 32'h01020304, 32'h24, 2, 1'b0);
    rd("rd24", 32'h24, 32'h01020304, 16'h0304, 8'h04);

    // Range boundary: the last word is accepted, the first byte past it is not.
    store("w3ffc", 32'h3FFC, 2'b11, 32'hA5A5C3C3, 32'h3FFC, 2, 1'b0);
    rd("rd3fff", 32'h3FFF, 32'hA5A5C3C3, 16'hA5A5, 8'hA5);
    store("b4000", 32'h4000, 2'b01, 32'h00000012, 32'h4000, 1, 1'b1);
    rd("rd4000", 32'h4000, 32'h0, 16'h0, 8'h0);

    // Reset during READ discards the pending byte store.
    store("w30", 32'h30, 2'b11, 32'hCAFEF00D, 32'h30, 2, 1'b0);
    rd("rd30a", 32'h30, 32'hCAFEF00D, 16'hF00D, 8'h0D);
    address    = 32'h30;
    write_mode = 2'b01;
    write_byte = 8'h77;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst.done", 32'(done), 32'd0);
    chk("mid_rst.error", 32'(error), 32'd0);
    chk("mid_rst.word", word_output, 32'd0);
    write_mode = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst.done", 32'(done), 32'd0);
    rd("rd30b", 32'h30, 32'hCAFEF00D, 16'hF00D, 8'h0D);
    store("b30", 32'h30, 2'b01, 32'h00000077, 32'h30, 3, 1'b0);
    rd("rd30c", 32'h30, 32'hCAFEF077, 16'hF077, 8'h77);

    // Address and data changes after capture are ignored.
    store("w40", 32'h40, 2'b11, 32'h55555555, 32'h40, 2, 1'b0);
    store("b31", 32'h31, 2'b01, 32'h00000099, 32'h40, 3, 1'b0);
    rd("rd30d", 32'h30, 32'hCAFE9977, 16'h9977, 8'h77);
    rd("rd40", 32'h40, 32'h55555555, 16'h5555, 8'h55);

    // Mode dropped to 0 right after capture: the store still completes.
    address         = 32'h44;
    write_mode      = 2'b11;
    write_word      = 32'h0BADF00D;
    tick();
    write_mode = 2'b00;
    tick();
    chk("drop.done", 32'(done), 32'd1);
    tick();
    tick();
    rd("rd44", 32'h44, 32'h0BADF00D, 16'hF00D, 8'h0D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
